// File: rtl/resp_frame_pkg.sv
// resp_frame_pkg: definitions shared by the response framing buffer.
//   state_t        - framer FSM states (IDLE, HDR, PAY, PAD)
//   HDR_MAGIC      - constant upper half of every frame header word
//   SEQ_W / VALN_W - widths of the header sequence and valid-count fields
//   hdr_word()     - assembles a header word from its fields
package resp_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        PAD  = 2'd3
    } state_t;

    localparam int MAGIC_W = 16;
    localparam int SEQ_W   = 8;
    localparam int VALN_W  = 8;

    localparam logic [MAGIC_W-1:0] HDR_MAGIC = 16'hA5A5;

    function automatic logic [31:0] hdr_word(input logic [SEQ_W-1:0]  seq,
                                             input logic [VALN_W-1:0] valn);
        return {HDR_MAGIC, seq, valn};
    endfunction

endpackage

// File: rtl/resp_frame_fifo.sv
// resp_frame_fifo: synchronous show-ahead circular FIFO for frame payload.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   wr_en      : write request; dropped when full unless rd_en is also high
//   wr_data    : word to store
//   rd_en      : pop the head word (ignored when empty)
//   rd_data    : head word, valid whenever count != 0
//   count      : number of stored words, 0..DEPTH
//   drop       : pulses for one cycle when a write is rejected
module resp_frame_fifo #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
    assign wr_ok = wr_en && (!full || rd_ok);
    assign drop  = wr_en && !wr_ok;

    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/resp_frame_buf.sv
// resp_frame_buf: buffers result words from the chip-side logic and presents
// them to the host as fixed-length frames: one header word
// {A5A5, frame_seq, valid_n} followed by FRAME_WORDS-1 payload/pad words.
//   CLK         : clock, rising edge
//   rst_n       : asynchronous active-low reset (release synchronised upstream)
//   FIFOB_IN    : result word; FIFOB_wen qualifies it
//   frame_rd_en : host pops the presented word (ignored when no frame)
//   frame_dout  : presented word, show-ahead; 0 when no frame
//   frame_ready : a frame is being presented
//   overflow    : sticky, an input word was dropped on a full buffer
//   frame_seq   : completed frame count, wraps at 256
// Build option: define RESP_FRAME_TIMEOUT_EN to flush a partial frame after
// TIMEOUT_CYC idle cycles, padding it with zero words (PAD state). Without it,
// a frame starts only once FRAME_WORDS-1 payload words are buffered.
module resp_frame_buf
    import resp_frame_pkg::*;
#(
    parameter int FRAME_WORDS = 16,
    parameter int BUF_DEPTH   = 64,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [31:0] FIFOB_IN,
    input  logic        FIFOB_wen,
    input  logic        frame_rd_en,
    output logic [31:0] frame_dout,
    output logic        frame_ready,
    output logic        overflow,
    output logic [7:0]  frame_seq
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_THR = CNT_W'(FRAME_WORDS - 1);
    localparam logic [VALN_W-1:0] LAST_IDX = VALN_W'(FRAME_WORDS - 1);

    if (FRAME_WORDS < 2 || FRAME_WORDS > 64 || BUF_DEPTH < FRAME_WORDS ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("resp_frame_buf: illegal parameter combination");
    end

    state_t            state, state_nxt;
    logic [VALN_W-1:0] valid_n, valid_nxt;
    logic [VALN_W-1:0] word_cnt, wcnt_nxt;
    logic [VALN_W-1:0] wcnt_inc;
    logic [SEQ_W-1:0]  seq_nxt;
    logic              pop;
    logic [31:0]       head;
    logic [CNT_W-1:0]  count;
    logic              drop;

    resp_frame_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (rst_n),
        .wr_en   (FIFOB_wen),
        .wr_data (FIFOB_IN),
        .rd_en   (pop),
        .rd_data (head),
        .count   (count),
        .drop    (drop)
    );

`ifdef RESP_FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

    logic [TO_W-1:0] to_cnt;
    logic            timeout;

    // Counts only while idle with data waiting; saturates at the limit.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state != IDLE || FIFOB_wen || count == '0) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIM) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout = (to_cnt == TO_LIM);
`endif

    assign wcnt_inc = word_cnt + 1'b1;

    // State register; valid_n is latched on entry to HDR so later writes
    // cannot change the frame in progress.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid_n   <= '0;
            word_cnt  <= '0;
            frame_seq <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_n   <= valid_nxt;
            word_cnt  <= wcnt_nxt;
            frame_seq <= seq_nxt;
            overflow  <= overflow | drop;
        end
    end

    // Next-state logic. word_cnt counts words popped after the header.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid_n;
        wcnt_nxt  = word_cnt;
        seq_nxt   = frame_seq;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count >= FULL_THR) begin
                    state_nxt = HDR;
                    valid_nxt = LAST_IDX;
                end
`ifdef RESP_FRAME_TIMEOUT_EN
                else if (timeout && count != '0) begin
                    state_nxt = HDR;
                    valid_nxt = VALN_W'(count);
                end
`endif
            end
            HDR: begin
                wcnt_nxt = '0;
                if (frame_rd_en) state_nxt = PAY;
            end
            PAY: begin
                if (frame_rd_en) begin
                    pop      = 1'b1;
                    wcnt_nxt = wcnt_inc;
                    if (wcnt_inc == valid_n) begin
`ifdef RESP_FRAME_TIMEOUT_EN
                        if (valid_n < LAST_IDX) begin
                            state_nxt = PAD;
                        end else begin
                            state_nxt = IDLE;
                            seq_nxt   = frame_seq + 1'b1;
                        end
`else
                        state_nxt = IDLE;
                        seq_nxt   = frame_seq + 1'b1;
`endif
                    end
                end
            end
`ifdef RESP_FRAME_TIMEOUT_EN
            PAD: begin
                if (frame_rd_en) begin
                    wcnt_nxt = wcnt_inc;
                    if (wcnt_inc == LAST_IDX) begin
                        state_nxt = IDLE;
                        seq_nxt   = frame_seq + 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; IDLE (including reset) presents 0.
    always_comb begin
        frame_dout  = '0;
        frame_ready = 1'b0;
        case (state)
            HDR: begin
                frame_dout  = hdr_word(frame_seq, valid_n);
                frame_ready = 1'b1;
            end
            PAY: begin
                frame_dout  = head;
                frame_ready = 1'b1;
            end
`ifdef RESP_FRAME_TIMEOUT_EN
            PAD: begin
                frame_ready = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/resp_frame_buf.md
RESP_FRAME_BUF -- requirements
Module: resp_frame_buf

Interface
REQ-001 Parameter FRAME_WORDS, default 16: words per frame, header included; legal range 2..64.
REQ-002 Parameter BUF_DEPTH, default 64: payload buffer depth in words; power of two, at least FRAME_WORDS.
REQ-003 Parameter TIMEOUT_CYC, default 1024: idle cycles before a partial frame is flushed.
REQ-004 Port CLK, input, 1 bit: single clock, rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port FIFOB_IN, input, 32 bits: result word from the chip-side FPGA logic.
REQ-007 Port FIFOB_wen, input, 1 bit: FIFOB_IN valid this cycle.
REQ-008 Port frame_rd_en, input, 1 bit: host pops the current output word.
REQ-009 Port frame_dout, output, 32 bits: current output word, show-ahead.
REQ-010 Port frame_ready, output, 1 bit: a frame is being presented.
REQ-011 Port overflow, output, 1 bit: sticky flag, at least one input word dropped.
REQ-012 Port frame_seq, output, 8 bits: count of completed frames, wraps at 256.

Function
REQ-013 Every accepted FIFOB_IN word SHALL enter the circular payload buffer in order.
REQ-014 When the buffer is full, a write SHALL be dropped and overflow set, unless a pop occurs in the same cycle, in which case the write SHALL be accepted.
REQ-015 The FSM SHALL have four states: IDLE, HDR, PAY and PAD.
REQ-016 In IDLE, when buffer count is at least FRAME_WORDS-1, the FSM SHALL go to HDR with valid_n = FRAME_WORDS-1.
REQ-017 In IDLE, on timeout with count at least 1, the FSM SHALL go to HDR with valid_n = count.
REQ-018 frame_ready SHALL be 1 in HDR, PAY and PAD, and 0 in IDLE.
REQ-019 In HDR, frame_dout SHALL be {16'hA5A5, frame_seq, valid_n[7:0]}; frame_rd_en SHALL move the FSM to PAY.
REQ-020 In PAY, frame_dout SHALL be the buffer head, and frame_rd_en SHALL pop it.
REQ-021 After valid_n pops, the FSM SHALL go to PAD if valid_n < FRAME_WORDS-1, else to IDLE.
REQ-022 In PAD, frame_dout SHALL be 32'h0; the FSM SHALL stay until the frame totals FRAME_WORDS words, then go to IDLE.
REQ-023 frame_seq SHALL increment on the final word pop of each frame.
REQ-024 frame_rd_en outside a frame SHALL be ignored, and no state SHALL change.
REQ-025 The timeout counter SHALL count cycles in IDLE with count > 0 and no write, clear on any write, and fire at TIMEOUT_CYC.
REQ-026 Writes during a frame SHALL be buffered and SHALL NOT alter the frame in progress; valid_n is latched at entry to HDR.
REQ-027 Output latency: a word written at cycle t SHALL be poppable no earlier than cycle t+2.

Reset
REQ-028 On rst_n low, pointers, count, timeout counter, frame_seq and overflow SHALL clear to 0, and the FSM SHALL enter IDLE.
REQ-029 While in reset, frame_ready SHALL be 0 and frame_dout SHALL be 32'h0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame and discard all buffered words.
REQ-031 Reset SHALL release synchronously to CLK, via the existing reset synchroniser upstream.

Configuration
REQ-032 Macro RESP_FRAME_TIMEOUT_EN defined: the timeout flush of REQ-017 and REQ-025 and the PAD state SHALL be present.
REQ-033 Macro RESP_FRAME_TIMEOUT_EN undefined: frames SHALL start only on a full payload, with no timeout counter and PAD unreachable and removed.

Structure
REQ-034 A shared package resp_frame_pkg SHALL hold the FSM state enum, the header magic 16'hA5A5, and the header field widths.
REQ-035 The payload storage SHALL be a sub-module, resp_frame_fifo: a synchronous show-ahead FIFO with count output.

Verification
REQ-036 Write 15 words 1..15, FRAME_WORDS=16 -> header 32'hA5A5_000F, then words 1..15, frame_seq becomes 1.
REQ-037 Write 3 words, idle 1024 cycles (macro on) -> header 32'hA5A5_0003, 3 words, 12 zero words.
REQ-038 Same stimulus with the macro off -> frame_ready stays 0 indefinitely.
REQ-039 Write 65 words with no reads, BUF_DEPTH=64 -> overflow=1, word 65 lost, first frame intact.
REQ-040 Assert rst_n low after the header and 4 pops -> all outputs 0, buffer empty, next frame seq byte 0x00.
REQ-041 Stream 256 full frames -> frame_seq wraps to 0, and the 257th header seq byte is 0x00.
